// File: rtl/arb_pkg.sv
// Shared arbitration package.
// Holds the default requester count and weight width, an index-width helper,
// and the per-cycle decision type used by the weighted round-robin scheduler.
package arb_pkg;

  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_QWID     = 4;

  // Width of an index into n entries. A single-entry arbiter still needs
  // one bit so that the ports keep a legal width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    DEC_IDLE   = 2'd0,
    DEC_HOLD   = 2'd1,
    DEC_ROTATE = 2'd2
  } dec_e;

endpackage

// File: rtl/rot_pridec.sv
// Rotating first-one priority decoder.
// Finds the first set bit of vec, searching upward from index start and
// wrapping modulo N, so that the entry just below start is searched last.
// Ports:
//   vec   - candidate vector
//   start - index searched first
//   found - at least one bit of vec is set
//   idx   - index of the first set bit in rotated order (0 when none)
module rot_pridec #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  function automatic int wrap_idx(input int s, input int k);
    return (s + k) % N;
  endfunction

  // Walk from the far end back toward start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[wrap_idx(int'(start), k)]) begin
        found = 1'b1;
        idx   = IW'(wrap_idx(int'(start), k));
      end
    end
  end

endmodule

// File: rtl/wrr_sched.sv
// Weighted round-robin scheduler for NUM_REQS FIFOs sharing one pop port.
// The current owner keeps the grant for up to weight[owner] consecutive
// packets, after which the turn passes to the next eligible requester.
// Grants are combinational so the FIFO pop lands in the decision cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   blk       - downstream backpressure; no grant while high
//   reqs      - per-FIFO request (~empty)
//   weights   - flat weights, requester i at [(i+1)*QWID-1 : i*QWID]
//   gnt       - one-hot or zero grant (FIFO pop)
//   gnt_vld   - |gnt
//   gnt_idx   - granted index, 0 when no grant
//   gnt_last  - this grant consumes the owner's final credit
//
// decision | meaning
// IDLE     | blk high or nothing eligible; owner/credit held
// HOLD     | owner still eligible with credit left; credit decrements
// ROTATE   | turn passes to next eligible after owner; credit reloads
module wrr_sched
  import arb_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  parameter int QWID     = DEF_QWID,
  parameter int IW       = idx_w(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*QWID-1:0] weights,
  output logic [NUM_REQS-1:0]      gnt,
  output logic                     gnt_vld,
  output logic [IW-1:0]            gnt_idx,
  output logic                     gnt_last
);

  logic [IW-1:0]       owner_q, owner_d;
  logic [QWID-1:0]     credit_q, credit_d;
  logic [NUM_REQS-1:0] eligible;
  logic [IW-1:0]       search_start;
  logic                rot_found;
  logic [IW-1:0]       rot_idx;
  logic [QWID-1:0]     w_new;
  dec_e                dec;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = reqs[i] & (weights[i*QWID +: QWID] != '0);
    end
  end

  // Owner is searched last, so the search begins one past it.
  assign search_start = (int'(owner_q) == NUM_REQS - 1) ? '0 : owner_q + IW'(1);

  rot_pridec #(
    .N  (NUM_REQS),
    .IW (IW)
  ) u_rot_pridec (
    .vec   (eligible),
    .start (search_start),
    .found (rot_found),
    .idx   (rot_idx)
  );

  assign w_new = weights[int'(rot_idx)*QWID +: QWID];

  // Outputs are gated by rst so they read zero during reset even though
  // they are combinational from inputs.
  always_comb begin
    dec      = DEC_IDLE;
    gnt_idx  = '0;
    gnt_last = 1'b0;
    owner_d  = owner_q;
    credit_d = credit_q;
    if (!rst && !blk) begin
      if (eligible[owner_q] && (credit_q != '0)) begin
        dec      = DEC_HOLD;
        gnt_idx  = owner_q;
        gnt_last = (credit_q == QWID'(1));
        credit_d = credit_q - QWID'(1);
      end else if (rot_found) begin
        dec      = DEC_ROTATE;
        gnt_idx  = rot_idx;
        gnt_last = (w_new == QWID'(1));
        owner_d  = rot_idx;
        credit_d = w_new - QWID'(1);
      end
    end
  end

  assign gnt_vld = (dec != DEC_IDLE);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= IW'(NUM_REQS - 1);
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_wrr_sched.sv
module tb_wrr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk;
  logic [3:0]  reqs;
  logic [15:0] weights;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic        gnt_last;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    logic       vld;
    logic [1:0] idx;
    logic       last;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [3:0]  cur_reqs;
  logic [15:0] cur_w;

  wrr_sched #(.NUM_REQS(4), .QWID(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .blk      (blk),
    .reqs     (reqs),
    .weights  (weights),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx),
    .gnt_last (gnt_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [3:0] eg;
    if (sb.size() == 0) begin
      n_asrt++;
      n_fail++;
      $error("FAIL scoreboard: empty queue at check");
      return;
    end
    e  = sb.pop_front();
    eg = e.vld ? (4'b0001 << e.idx) : 4'b0000;
    chk({e.tag, ".gnt"},      {28'd0, gnt},      {28'd0, eg});
    chk({e.tag, ".gnt_vld"},  {31'd0, gnt_vld},  {31'd0, e.vld});
    chk({e.tag, ".gnt_idx"},  {30'd0, gnt_idx},  {30'd0, e.vld ? e.idx : 2'd0});
    chk({e.tag, ".gnt_last"}, {31'd0, gnt_last}, {31'd0, e.last});
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge.
  task automatic step(input logic b, input logic ev, input logic [1:0] ei,
                      input logic el, input string tag);
    blk     = b;
    reqs    = cur_reqs;
    weights = cur_w;
    sb.push_back('{ev, ei, el, tag});
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic g(input logic [1:0] idx, input logic last, input string tag);
    step(1'b0, 1'b1, idx, last, tag);
  endtask

  // Reset asserted between edges; outputs must drop with inputs still active.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    sb.push_back('{1'b0, 2'd0, 1'b0, tag});
    check_out();
    reqs = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    blk     = 1'b0;
    reqs    = 4'b1111;
    weights = 16'h2222;
    #3;
    sb.push_back('{1'b0, 2'd0, 1'b0, "reset_state"});
    check_out();
    do_reset("reset_init");

    // All weights 2, all requesting.
    cur_reqs = 4'b1111;
    cur_w    = 16'h2222;
    g(0, 0, "w2_a"); g(0, 1, "w2_b"); g(1, 0, "w2_c"); g(1, 1, "w2_d");
    g(2, 0, "w2_e"); g(2, 1, "w2_f"); g(3, 0, "w2_g"); g(3, 1, "w2_h");
    g(0, 0, "w2_i");

    // Mixed weights {w3=2,w2=0,w1=3,w0=1}; index 2 is skipped.
    do_reset("reset_mix");
    cur_w = 16'h2031;
    g(0, 1, "mix_a"); g(1, 0, "mix_b"); g(1, 0, "mix_c"); g(1, 1, "mix_d");
    g(3, 0, "mix_e"); g(3, 1, "mix_f"); g(0, 1, "mix_g"); g(1, 0, "mix_h");

    // Backpressure with owner 1 holding its last credit.
    do_reset("reset_blk");
    cur_w = 16'h2222;
    g(0, 0, "blk_a"); g(0, 1, "blk_b"); g(1, 0, "blk_c");
    step(1'b1, 1'b0, 2'd0, 1'b0, "blk_hi1");
    step(1'b1, 1'b0, 2'd0, 1'b0, "blk_hi2");
    step(1'b1, 1'b0, 2'd0, 1'b0, "blk_hi3");
    g(1, 1, "blk_d"); g(2, 0, "blk_e");

    // Owner 0 (weight 3) drops after one grant, forfeits, later reloads 3.
    do_reset("reset_drop");
    cur_w = 16'h3333;
    g(0, 0, "drop_a");
    cur_reqs = 4'b1110;
    g(1, 0, "drop_b");
    cur_reqs = 4'b0011;
    g(1, 0, "drop_c"); g(1, 1, "drop_d");
    g(0, 0, "drop_e"); g(0, 0, "drop_f"); g(0, 1, "drop_g");
    g(1, 0, "drop_h");

    // Weight change only applies at the next rotate.
    do_reset("reset_wchg");
    cur_reqs = 4'b1111;
    cur_w    = 16'h3333;
    g(0, 0, "wchg_a");
    cur_w = 16'h3331;
    g(0, 0, "wchg_b"); g(0, 1, "wchg_c"); g(1, 0, "wchg_d");

    // Single requester 3 with weight 1.
    do_reset("reset_solo");
    cur_reqs = 4'b1000;
    cur_w    = 16'h1111;
    g(3, 1, "solo_a"); g(3, 1, "solo_b"); g(3, 1, "solo_c"); g(3, 1, "solo_d");

    // Only a zero-weight requester: never granted.
    cur_reqs = 4'b0100;
    cur_w    = 16'h1011;
    step(1'b0, 1'b0, 2'd0, 1'b0, "zero_w_a");
    step(1'b0, 1'b0, 2'd0, 1'b0, "zero_w_b");

    // Async reset mid-burst discards credit.
    do_reset("reset_burst");
    cur_reqs = 4'b1111;
    cur_w    = 16'h2222;
    g(0, 0, "burst_a"); g(0, 1, "burst_b"); g(1, 0, "burst_c");
    reqs    = cur_reqs;
    weights = cur_w;
    do_reset("midrst");
    g(0, 0, "post_a"); g(0, 1, "post_b"); g(1, 0, "post_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/wrr_sched.md
WRR_SCHED -- requirements
Module: wrr_sched

Interface
REQ-001 The block SHALL take parameter NUM_REQS, default 4: number of requesters (FIFOs) sharing one pop port.
REQ-002 The block SHALL take parameter QWID, default 4: width of each per-requester weight, in packets per turn.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port blk, input, 1 bit: downstream backpressure; no grant while high.
REQ-006 The block SHALL have port reqs, input, NUM_REQS bits: request per FIFO, driven as ~empty.
REQ-007 The block SHALL have port weights, input, NUM_REQS*QWID bits: flat weights; requester i in bits [(i+1)*QWID-1:i*QWID].
REQ-008 The block SHALL have port gnt, output, NUM_REQS bits: one-hot or zero grant, wired directly to FIFO pop.
REQ-009 The block SHALL have port gnt_vld, output, 1 bit: equal to |gnt.
REQ-010 The block SHALL have port gnt_idx, output, $clog2(NUM_REQS) bits: index of the granted requester; 0 when gnt_vld is low.
REQ-011 The block SHALL have port gnt_last, output, 1 bit: the current grant consumes the owner's final credit.

Function
REQ-012 The block SHALL define eligible[i] = reqs[i] & (weight[i] != 0); zero-weight requesters are never granted.
REQ-013 The block SHALL hold state owner (index) and credit (QWID bits).
REQ-014 gnt, gnt_vld, gnt_idx and gnt_last SHALL be combinational from state, reqs, weights and blk, with zero-cycle latency, so pop lands in the same cycle as the decision.
REQ-015 HOLD: if blk=0, eligible[owner]=1 and credit!=0, the block SHALL grant owner and set credit<=credit-1 on the next edge.
REQ-016 ROTATE: if blk=0 and HOLD does not apply, the block SHALL grant the first eligible index searched from owner+1 upward, wrapping modulo NUM_REQS, with owner searched last.
REQ-017 On ROTATE, the block SHALL update owner<=new index and credit<=weight[new]-1 on the next edge.
REQ-018 IDLE: if blk=1 or no requester is eligible, the block SHALL drive gnt=0 and leave owner and credit unchanged.
REQ-019 An owner that drops its request with credit remaining SHALL forfeit that credit; on its next turn it SHALL reload its full weight.
REQ-020 gnt_last SHALL be 1 when HOLD applies with credit==1, or ROTATE applies with weight[new]==1.
REQ-021 A change in weights SHALL take effect only on the next ROTATE; a credit already loaded SHALL NOT be altered.
REQ-022 The block SHALL NOT grant a requester whose reqs bit is 0, and SHALL NOT assert more than one gnt bit.

Reset
REQ-023 On rst=1, independent of clk, owner SHALL reset to NUM_REQS-1 and credit to 0, so the first search starts at index 0.
REQ-024 While rst=1, all outputs SHALL be 0.
REQ-025 Asserting rst mid-turn SHALL discard any remaining credit.

Structure
REQ-026 A shared package arb_pkg SHALL hold the default NUM_REQS and QWID constants and an idx width function.
REQ-027 The rotating first-one search SHALL be a sub-module rot_pridec, with inputs vector and start index and outputs found and index, reusing the existing priority-decoder style.
REQ-028 The state SHALL be the owner and credit registers only; no other storage.

Verification (NUM_REQS=4, QWID=4)
REQ-029 Reset release, reqs=4'b1111, all weights 2: grant index sequence SHALL be 0,0,1,1,2,2,3,3,0, with gnt_last on every second grant.
REQ-030 Weights {w0=1,w1=3,w2=0,w3=2}, all requesting: sequence SHALL be 0,1,1,1,3,3,0,...; index 2 SHALL never be granted.
REQ-031 Owner 1 with credit 1 left, blk high 3 cycles: gnt SHALL be 0 for 3 cycles, then one grant to 1 with gnt_last=1, then 2.
REQ-032 Owner 0 (weight 3) drops its request after 1 grant: requester 1 SHALL be granted in that same cycle; 0 SHALL later return with 3 grants.
REQ-033 Only reqs[3] high, weight 1: gnt SHALL be 4'b1000 every cycle, with gnt_last=1 each cycle.
REQ-034 Async rst pulse between edges mid-burst: gnt SHALL be 0 immediately; after release with all requesting, the first grant SHALL go to 0.
